// File: rtl/timer_apb_seq_pkg.sv
// timer_pkg: shared encodings for timer_apb_seq and its APB transfer engine
package timer_pkg;
  typedef enum logic [3:0] {IDLE, WR_TDR, WR_TCR, POLL_WAIT, RD_TSR, CLR_TSR, WR_STOP, DONE, ERR} state_t;
  typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS} xfer_t;
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_TDR  = 4'b0001;
  localparam logic [3:0] SEL_TCR  = 4'b0010;
  localparam logic [3:0] SEL_TSR  = 4'b0100;
  localparam int TSR_OF = 0;
  localparam int TSR_UF = 1;
  localparam int TCR_RUN_BIT_DEF = 7;
endpackage

// File: rtl/timer_apb_seq_if.sv
// timer_apb_seq_if: APB link between the sequencer and the timer register slave
interface timer_apb_seq_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [3:0] select_reg;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  modport master (output psel, penable, pwrite, select_reg, pwdata, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, select_reg, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/timer_apb_seq_xfer.sv
// apb_xfer_master: one SETUP/ACCESS transfer per request; watchdog under TIMER_APB_SEQ_TIMEOUT_EN
module apb_xfer_master
  import timer_pkg::*;
`ifdef TIMER_APB_SEQ_TIMEOUT_EN
#(
  parameter int PREADY_TIMEOUT = 16
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       wr_i,
  input  logic [3:0] sel_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic       slverr_o,
  output logic [7:0] rdata_o,
  timer_apb_seq_if.master apb
);
  xfer_t ph_q, ph_d;
  logic wr_q;
  logic [3:0] sel_q;
  logic [7:0] wdata_q;
  logic timeout;
`ifdef TIMER_APB_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(PREADY_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(PREADY_TIMEOUT - 1);
  logic [WD_W-1:0] wd_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) wd_q <= '0;
    else wd_q <= (ph_q == X_ACCESS) ? wd_q + 1'b1 : '0;
  assign timeout = ph_q == X_ACCESS && !apb.pready && wd_q == WD_LAST;
`else
  assign timeout = 1'b0;
`endif
  // a timeout completes the transfer as an error so the caller needs no extra path
  assign done_o   = ph_q == X_ACCESS && (apb.pready || timeout);
  assign slverr_o = ph_q == X_ACCESS && (apb.pready ? apb.pslverr : timeout);
  assign rdata_o  = apb.prdata;
  always_comb
    ph_d = ph_q == X_IDLE ? (req_i ? X_SETUP : X_IDLE) : ph_q == X_SETUP ? X_ACCESS : done_o ? X_IDLE : X_ACCESS;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ph_q <= X_IDLE;
      wr_q <= 1'b0;
      sel_q <= SEL_NONE;
      wdata_q <= '0;
    end else begin
      ph_q <= ph_d;
      if (ph_q == X_IDLE && req_i) begin
        wr_q <= wr_i;
        sel_q <= sel_i;
        wdata_q <= wdata_i;
      end
    end
  assign apb.psel       = ph_q != X_IDLE;
  assign apb.penable    = ph_q == X_ACCESS;
  assign apb.select_reg = apb.psel ? sel_q : SEL_NONE;
  assign apb.pwrite     = wr_q;
  assign apb.pwdata     = wdata_q;
endmodule

// File: rtl/timer_apb_seq.sv
// timer_apb_seq: APB sequencer that arms the timer, services of/uf events and stops it
// Optional PREADY watchdog enabled by defining TIMER_APB_SEQ_TIMEOUT_EN.
module timer_apb_seq
  import timer_pkg::*;
#(
  parameter int TCR_RUN_BIT = TCR_RUN_BIT_DEF,
  parameter int CNT_W = 8,
  parameter int POLL_GAP = 4
`ifdef TIMER_APB_SEQ_TIMEOUT_EN
  , parameter int PREADY_TIMEOUT = 16
`endif
)(
  input  logic             pclk,
  input  logic             preset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_tdr,
  input  logic [7:0]       cfg_tcr,
  input  logic [CNT_W-1:0] cfg_events,
  timer_apb_seq_if.master  apb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] event_cnt,
  output logic [1:0]       last_flags
);
  localparam logic [3:0] GAP_LAST = (POLL_GAP == 0) ? 4'd0 : 4'(POLL_GAP - 1);
  state_t st_q, st_d;
  logic [7:0] tdr_q, tcr_q, tcr_run, tcr_stop, wdata, rdata;
  logic [CNT_W-1:0] tgt_q, cnt_q, cnt_d;
  logic [1:0] flg_q, flg_d;
  logic [5:0] tsr_q, tsr_d;
  logic [3:0] gap_q, gap_d, sel;
  logic err_q, err_d, req, wr, x_done, x_err;
  apb_xfer_master
`ifdef TIMER_APB_SEQ_TIMEOUT_EN
    #(.PREADY_TIMEOUT(PREADY_TIMEOUT))
`endif
  u_xfer (
    .clk(pclk), .rst(preset), .req_i(req), .wr_i(wr), .sel_i(sel), .wdata_i(wdata),
    .done_o(x_done), .slverr_o(x_err), .rdata_o(rdata), .apb(apb)
  );
  always_comb begin
    tcr_run = tcr_q;
    tcr_run[TCR_RUN_BIT] = 1'b1;
    tcr_stop = tcr_q;
    tcr_stop[TCR_RUN_BIT] = 1'b0;
  end
  assign gap_d = (st_q == POLL_WAIT && gap_q != GAP_LAST) ? gap_q + 1'b1 : '0;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    flg_d = flg_q;
    tsr_d = tsr_q;
    err_d = err_q;
    req = 1'b0;
    wr = 1'b1;
    sel = SEL_NONE;
    wdata = '0;
    case (st_q)
      IDLE: if (start) begin
        st_d = WR_TDR;
        cnt_d = '0;
        err_d = 1'b0;
      end
      WR_TDR: begin
        req = 1'b1;
        sel = SEL_TDR;
        wdata = tdr_q;
        if (x_done) st_d = x_err ? ERR : WR_TCR;
      end
      WR_TCR: begin
        req = 1'b1;
        sel = SEL_TCR;
        wdata = tcr_run;
        if (x_done) st_d = x_err ? ERR : POLL_WAIT;
      end
      POLL_WAIT: st_d = abort ? WR_STOP : (gap_q == GAP_LAST) ? RD_TSR : POLL_WAIT;
      RD_TSR: begin
        req = 1'b1;
        wr = 1'b0;
        sel = SEL_TSR;
        if (x_done) begin
          if (x_err) st_d = ERR;
          else if (rdata[TSR_UF:TSR_OF] == 2'b00) st_d = POLL_WAIT;
          else begin
            st_d = CLR_TSR;
            flg_d = rdata[TSR_UF:TSR_OF];
            tsr_d = rdata[7:2];
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          end
        end
      end
      CLR_TSR: begin
        req = 1'b1;
        sel = SEL_TSR;
        wdata = {tsr_q, 2'b00};
        if (x_done) st_d = x_err ? ERR : (cnt_q == tgt_q || abort) ? WR_STOP : POLL_WAIT;
      end
      WR_STOP: begin
        req = 1'b1;
        sel = SEL_TCR;
        wdata = tcr_stop;
        if (x_done) st_d = x_err ? ERR : DONE;
      end
      DONE, ERR: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (st_d == ERR) err_d = 1'b1;
  end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      st_q <= IDLE;
      cnt_q <= '0;
      flg_q <= '0;
      tsr_q <= '0;
      err_q <= 1'b0;
      gap_q <= '0;
      tdr_q <= '0;
      tcr_q <= '0;
      tgt_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      flg_q <= flg_d;
      tsr_q <= tsr_d;
      err_q <= err_d;
      gap_q <= gap_d;
      if (st_q == IDLE && start) begin
        tdr_q <= cfg_tdr;
        tcr_q <= cfg_tcr;
        tgt_q <= (cfg_events == '0) ? CNT_W'(1) : cfg_events;
      end
    end
  assign busy = !(st_q inside {IDLE, DONE, ERR});
  assign done = st_q == DONE;
  assign err = err_q;
  assign event_cnt = cnt_q;
  assign last_flags = flg_q;
endmodule

// File: tb/tb_timer_apb_seq.sv
// tb_timer_apb_seq: directed and randomized runs against a write-list reference model
module tb_timer_apb_seq;
  logic pclk, preset, start, abort;
  logic [7:0] cfg_tdr, cfg_tcr, cfg_events;
  logic busy, done, err;
  logic [7:0] event_cnt;
  logic [1:0] last_flags;
  timer_apb_seq_if apb();
  timer_apb_seq dut (
    .pclk(pclk), .preset(preset), .start(start), .abort(abort),
    .cfg_tdr(cfg_tdr), .cfg_tcr(cfg_tcr), .cfg_events(cfg_events), .apb(apb),
    .busy(busy), .done(done), .err(err), .event_cnt(event_cnt), .last_flags(last_flags)
  );
  int errors, checks;
  int wait_states, err_at, rd_base, rd_total, xfer_total, ws;
  bit hang;
  logic [7:0] tsr_rsp[64];
  logic [11:0] wr_log[$];
  int acc_log[$];
  int done_cnt, psel_cyc, stab_err;
  logic [12:0] cap;
  initial begin
    pclk = 0;
    forever #5 pclk = ~pclk;
  end
  // slave model: wait states, scripted TSR reads, optional error/hang injection
  initial begin
    int idx;
    apb.pready = 0; apb.pslverr = 0; apb.prdata = 0;
    rd_total = 0; xfer_total = 0; ws = 0;
    forever begin
      @(negedge pclk);
      apb.pready = 0;
      apb.pslverr = 0;
      if (preset || !(apb.psel && apb.penable)) ws = 0;
      else if (hang || ws < wait_states) ws++;
      else begin
        apb.pready = 1;
        if (!apb.pwrite) begin
          idx = rd_total - rd_base;
          apb.prdata = (idx < 64) ? tsr_rsp[idx] : 8'h00;
          rd_total++;
        end
        if (xfer_total == err_at) apb.pslverr = 1;
        else if (apb.pwrite) wr_log.push_back({apb.select_reg, apb.pwdata});
        acc_log.push_back(ws + 1);
        xfer_total++;
      end
    end
  end
  // protocol monitor: stability SETUP..ACCESS, idle bus between transfers
  initial begin
    done_cnt = 0; psel_cyc = 0; stab_err = 0; cap = 0;
    forever begin
      @(negedge pclk);
      if (done === 1'b1) done_cnt++;
      if (apb.psel === 1'b1) psel_cyc++;
      if (apb.psel && !apb.penable) cap = {apb.pwrite, apb.select_reg, apb.pwdata};
      else if (apb.psel && apb.penable && cap !== {apb.pwrite, apb.select_reg, apb.pwdata}) stab_err++;
      else if (!apb.psel && (apb.penable || apb.select_reg != 4'b0000)) stab_err++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_end(output bit got);
    got = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge pclk);
      if (done === 1'b1 || err === 1'b1) begin
        got = 1;
        return;
      end
    end
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge pclk);
    start = 0;
  endtask
  task automatic run(input string tag, input logic [7:0] tdr, input logic [7:0] tcr,
                     input logic [7:0] ev, input int wst, input bit dup);
    logic [11:0] exp_wr[$];
    logic [1:0] exp_flg;
    int n, tgt, wb, db, ab;
    bit got;
    tgt = (ev == 0) ? 1 : int'(ev);
    n = 0;
    exp_flg = 2'b00;
    exp_wr.push_back({4'b0001, tdr});
    exp_wr.push_back({4'b0010, tcr | 8'h80});
    for (int i = 0; i < 64 && n < tgt; i++)
      if (tsr_rsp[i][1:0] != 2'b00) begin
        n++;
        exp_flg = tsr_rsp[i][1:0];
        exp_wr.push_back({4'b0100, tsr_rsp[i] & 8'hFC});
      end
    exp_wr.push_back({4'b0010, tcr & 8'h7F});
    wait_states = wst;
    rd_base = rd_total;
    wb = wr_log.size();
    ab = acc_log.size();
    db = done_cnt;
    cfg_tdr = tdr; cfg_tcr = tcr; cfg_events = ev;
    pulse_start();
    if (dup) begin
      repeat (5) @(negedge pclk);
      cfg_tdr = ~tdr;
      pulse_start();
    end
    wait_end(got);
    chk({tag, "_finished"}, 32'(got), 1);
    @(negedge pclk);
    chk({tag, "_done_once"}, done_cnt - db, 1);
    chk({tag, "_event_cnt"}, 32'(event_cnt), n);
    chk({tag, "_last_flags"}, 32'(last_flags), 32'(exp_flg));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_nwrites"}, wr_log.size() - wb, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && wb + i < wr_log.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), 32'(wr_log[wb + i]), 32'(exp_wr[i]));
    for (int i = ab; i < acc_log.size(); i++)
      chk($sformatf("%s_access_len%0d", tag, i - ab), acc_log[i], wst + 1);
    chk({tag, "_stable"}, stab_err, 0);
  endtask
  initial begin
    bit got;
    int pc, db, wb, n;
    logic [31:0] r;
    logic [7:0] v;
    errors = 0; checks = 0;
    preset = 1; start = 0; abort = 0;
    cfg_tdr = 0; cfg_tcr = 0; cfg_events = 0;
    wait_states = 0; err_at = -1; hang = 0; rd_base = 0;
    for (int i = 0; i < 64; i++) tsr_rsp[i] = 8'h00;
    repeat (3) @(negedge pclk);
    chk("rst_psel", 32'(apb.psel), 0);
    chk("rst_penable", 32'(apb.penable), 0);
    chk("rst_select", 32'(apb.select_reg), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_event_cnt", 32'(event_cnt), 0);
    chk("rst_last_flags", 32'(last_flags), 0);
    preset = 0;
    @(negedge pclk);
    tsr_rsp[2] = 8'h01;
    tsr_rsp[4] = 8'h02;
    run("plan", 8'h40, 8'h01, 8'd2, 0, 0);
    run("waits", 8'h40, 8'h01, 8'd2, 3, 1);
    for (int i = 0; i < 64; i++) tsr_rsp[i] = 8'h00;
    tsr_rsp[1] = 8'hAB;
    run("both_flags", 8'h11, 8'h22, 8'd0, 1, 0);
    // slave error on the TCR write
    wb = wr_log.size();
    db = done_cnt;
    rd_base = rd_total;
    err_at = xfer_total + 1;
    cfg_tdr = 8'h5A; cfg_tcr = 8'h03; cfg_events = 8'd1;
    pulse_start();
    wait_end(got);
    chk("slverr_finished", 32'(got), 1);
    chk("slverr_err", 32'(err), 1);
    chk("slverr_busy", 32'(busy), 0);
    pc = psel_cyc;
    repeat (20) @(negedge pclk);
    chk("slverr_no_more_xfers", psel_cyc - pc, 0);
    chk("slverr_no_done", done_cnt - db, 0);
    chk("slverr_nwrites", wr_log.size() - wb, 1);
    chk("slverr_tdr", 32'(wr_log[wb]), 32'({4'b0001, 8'h5A}));
    chk("slverr_err_sticky", 32'(err), 1);
    err_at = -1;
    for (int i = 0; i < 64; i++) tsr_rsp[i] = 8'h00;
    tsr_rsp[0] = 8'h01;
    rd_base = rd_total;
    db = done_cnt;
    pulse_start();
    chk("restart_err_cleared", 32'(err), 0);
    chk("restart_busy", 32'(busy), 1);
    wait_end(got);
    @(negedge pclk);
    chk("restart_done", done_cnt - db, 1);
    // abort after the first of five events
    for (int i = 0; i < 64; i++) tsr_rsp[i] = 8'h00;
    tsr_rsp[0] = 8'h05;
    rd_base = rd_total;
    wb = wr_log.size();
    db = done_cnt;
    cfg_tdr = 8'h40; cfg_tcr = 8'h01; cfg_events = 8'd5;
    pulse_start();
    for (int i = 0; i < 500 && event_cnt != 8'd1; i++) @(negedge pclk);
    chk("abort_first_event", 32'(event_cnt), 1);
    repeat (2) @(negedge pclk);
    abort = 1;
    wait_end(got);
    abort = 0;
    chk("abort_finished", 32'(got), 1);
    @(negedge pclk);
    chk("abort_done", done_cnt - db, 1);
    chk("abort_event_cnt", 32'(event_cnt), 1);
    chk("abort_err", 32'(err), 0);
    chk("abort_nwrites", wr_log.size() - wb, 4);
    if (wr_log.size() - wb == 4) begin
      chk("abort_clr", 32'(wr_log[wb + 2]), 32'({4'b0100, 8'h04}));
      chk("abort_stop", 32'(wr_log[wb + 3]), 32'({4'b0010, 8'h01}));
    end
    // randomized runs
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) begin
        r = $urandom;
        v = r[7:0];
        if (i < 40 && r[9:8] != 2'b00) v[1:0] = 2'b00;
        else if (i >= 40 && v[1:0] == 2'b00) v[0] = 1'b1;
        tsr_rsp[i] = v;
      end
      run($sformatf("rand%0d", k), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 4)),
          int'($urandom_range(0, 2)), k == 0);
    end
    // reset in the middle of the TCR ACCESS phase
    for (int i = 0; i < 64; i++) tsr_rsp[i] = 8'h00;
    wait_states = 3;
    rd_base = rd_total;
    cfg_tdr = 8'h77; cfg_tcr = 8'h00; cfg_events = 8'd1;
    pulse_start();
    for (int i = 0; i < 200 && !(apb.penable === 1'b1 && apb.select_reg === 4'b0010); i++) @(negedge pclk);
    chk("midrst_in_access", 32'(apb.penable), 1);
    preset = 1;
    #1;
    chk("midrst_psel", 32'(apb.psel), 0);
    chk("midrst_penable", 32'(apb.penable), 0);
    chk("midrst_select", 32'(apb.select_reg), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_event_cnt", 32'(event_cnt), 0);
    chk("midrst_last_flags", 32'(last_flags), 0);
    @(negedge pclk);
    preset = 0;
    wait_states = 0;
    @(negedge pclk);
`ifdef TIMER_APB_SEQ_TIMEOUT_EN
    hang = 1;
    rd_base = rd_total;
    pulse_start();
    for (int i = 0; i < 100 && !(apb.psel === 1'b1 && apb.penable === 1'b1); i++) @(negedge pclk);
    n = 0;
    while (apb.psel === 1'b1 && n < 100) begin
      n++;
      @(negedge pclk);
    end
    chk("timeout_access_cycles", n, 16);
    chk("timeout_err", 32'(err), 1);
    hang = 0;
    repeat (3) @(negedge pclk);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_apb_seq.md
Name: timer_apb_seq

Overview:
- APB master sequencer that configures and services the 16-bit timer's register slave without CPU involvement.
- On a start command it performs the following steps in order:
  - writes the data register (TDR);
  - writes the control register (TCR) with the run bit set;
  - polls the status register (TSR) for overflow/underflow;
  - clears each flag it finds;
  - after N events, rewrites TCR with the run bit cleared.
- Sits between a host/DMA-style command interface and the timer's APB slave port.

Parameters:
- TCR_RUN_BIT, 7, bit position in TCR that enables counting.
- CNT_W, 8, width of event target/counter.
- POLL_GAP, 4, idle cycles between consecutive TSR reads (0..15).
- PREADY_TIMEOUT, 16, max access-phase cycles before abort (used only with macro).

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous active-high reset
- start  in  1  one-cycle command pulse
- abort  in  1  level; request early stop
- cfg_tdr  in  8  value written to TDR
- cfg_tcr  in  8  TCR value; the run bit is forced by the block
- cfg_events  in  CNT_W  number of of/uf events to service (0 treated as 1)
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- select_reg  out  4  register one-hot: 4'b0001 TDR, 4'b0010 TCR, 4'b0100 TSR
- pwdata  out  8  write data
- prdata  in  8  read data (TSR[1]=uf, TSR[0]=of)
- pready  in  1  slave ready
- pslverr  in  1  slave error
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at normal completion
- err  out  1  sticky error; cleared by next accepted start
- event_cnt  out  CNT_W  events serviced so far
- last_flags  out  2  {uf,of} of most recent event

Behaviour:
- Reset values: all outputs 0; select_reg 4'b0000; FSM IDLE.
- APB transfer rules:
  - Every transfer is a SETUP cycle (psel=1, penable=0) followed by ACCESS cycles (psel=1, penable=1) held until pready=1.
  - select_reg, pwrite and pwdata are stable from SETUP through the completing ACCESS cycle.
  - Between transfers, psel=0, penable=0 and select_reg=0.
- States: IDLE, WR_TDR, WR_TCR, POLL_WAIT, RD_TSR, CLR_TSR, WR_STOP, DONE, ERR.
- Transitions:
  - IDLE: start → WR_TDR. busy=1, event_cnt=0, err=0. Inputs cfg_* are latched at start.
  - WR_TDR: write cfg_tdr. On complete → WR_TCR.
  - WR_TCR: write cfg_tcr with TCR_RUN_BIT=1. On complete → POLL_WAIT.
  - POLL_WAIT: count POLL_GAP cycles, then → RD_TSR.
  - RD_TSR: read TSR; prdata is sampled on the completing cycle.
    - If prdata[1:0]==0 → POLL_WAIT.
    - Otherwise last_flags=prdata[1:0] and event_cnt+1 → CLR_TSR.
  - CLR_TSR: write pwdata={prdata_latched[7:2], 2'b00}; the slave clears both flags on 00.
    - If event_cnt==target or abort=1 → WR_STOP.
    - Otherwise → POLL_WAIT.
  - WR_STOP: write cfg_tcr with TCR_RUN_BIT=0 → DONE.
  - DONE: one cycle. done=1, busy=0 → IDLE.
  - ERR: one cycle. err=1 (sticky), busy=0 → IDLE.
- pslverr=1 on the completing cycle of any transfer → ERR immediately. No stop write is attempted.
- abort:
  - Sampled in POLL_WAIT and after CLR_TSR.
  - Never interrupts an in-flight transfer.
  - In POLL_WAIT, abort → WR_STOP. done still pulses.
- start while busy is ignored.
- event_cnt saturates at its maximum value and does not wrap.
- Simultaneous uf and of: counted as a single event; last_flags=2'b11.
- Reset mid-transfer drops psel/penable asynchronously to 0.

Optional Feature:
- Macro: TIMER_APB_SEQ_TIMEOUT_EN.
- Defined: a watchdog counts ACCESS cycles. If pready is still 0 after PREADY_TIMEOUT cycles, the block deasserts psel/penable next cycle and enters ERR.
- Undefined: no watchdog; the block waits for pready indefinitely.

Decomposition:
- Shared package timer_pkg holds:
  - FSM state encoding;
  - select_reg one-hot constants SEL_TDR/SEL_TCR/SEL_TSR;
  - TSR flag bit indices;
  - TCR_RUN_BIT default.
- One sub-module, apb_xfer_master:
  - runs a single SETUP/ACCESS transfer (req, wr, sel, wdata → done, rdata, slverr);
  - contains the optional watchdog.
- The top-level FSM issues requests to it.

Test Plan:
- cfg_tdr=8'h40, cfg_tcr=8'h01, cfg_events=2, slave returns TSR=8'h01 on the 3rd read and 8'h02 on the 5th:
  - writes appear in this order: TDR=8'h40, TCR=8'h81, TSR clr=8'h00, TSR clr=8'h00, TCR=8'h01;
  - done pulses once; event_cnt=2; last_flags=2'b10.
- Slave inserts 3 wait states on each transfer → psel/select_reg/pwdata remain stable for 4 ACCESS cycles, and the order is unchanged.
- pslverr=1 on the TCR write → ERR, err=1, no further transfers, done=0; the next start clears err.
- abort asserted during POLL_WAIT after 1 of 5 events → TCR=8'h01 is written, done pulses, event_cnt=1.
- start pulsed while busy, plus preset asserted mid-ACCESS → start is ignored; psel=0 and all outputs are 0 immediately after reset.
- With TIMER_APB_SEQ_TIMEOUT_EN defined and PREADY_TIMEOUT=16, pready held 0 → psel drops after 16 ACCESS cycles and err=1.
